// File: rtl/seq_add2b_ctrl.sv
// Sequential W-bit add/subtract controller driving one shared 2-bit ripple slice.
// One slice per clock from the LSB up; the carry is held in a flop between slices.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last value
// RUN   | one 2-bit slice processed per clock, busy high
// DONE  | one-cycle done pulse, then back to IDLE
module seq_add2b_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int N  = W / 2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           carry;
  logic [SW-1:0]  step;

  logic [1:0]     slice_a;
  logic [1:0]     slice_b;
  logic [1:0]     slice_sum;
  logic           slice_c_mid;
  logic           slice_c_out;
  logic           last_step;

  // Operand slice select for the current step.
  always_comb begin
    slice_a = 2'b00;
    slice_b = 2'b00;
    for (int k = 0; k < N; k++) begin
      if (step == SW'(k)) begin
        slice_a = op_a[2*k +: 2];
        slice_b = op_b[2*k +: 2];
      end
    end
  end

  // Two chained full-adder cells; c_mid is the carry into the upper bit.
  always_comb begin
    slice_sum[0] = slice_a[0] ^ slice_b[0] ^ carry;
    slice_c_mid  = (slice_a[0] & slice_b[0]) | (slice_a[0] & carry) | (slice_b[0] & carry);
    slice_sum[1] = slice_a[1] ^ slice_b[1] ^ slice_c_mid;
    slice_c_out  = (slice_a[1] & slice_b[1]) | (slice_a[1] & slice_c_mid) |
                   (slice_b[1] & slice_c_mid);
  end

  assign last_step = (step == SW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      step  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            sum   <= '0;
            step  <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (step == SW'(k)) begin
              sum[2*k +: 2] <= slice_sum;
            end
          end
          carry <= slice_c_out;
          if (last_step) begin
            cout <= slice_c_out;
            ovf  <= slice_c_mid ^ slice_c_out;
            step <= '0;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
